ir_key_fifo: RTL

- Downstream stage of the IR remote decoder; consumes its Tecla/Ready output.
- The decoder presents a valid key as Ready held high for 3 consecutive cycles, with Tecla stable for the whole pulse.
- This block captures exactly one key per Ready pulse and queues keys in a small FIFO.
- Keys are delivered to the application through a valid/ack handshake, with overflow reporting and an optional repeat filter.

---
 rtl/ir_key_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/ir_key_fifo.sv
// ir_key_fifo: captures one key per decoder Ready pulse into a show-ahead FIFO with valid/ack drain.
// Optional repeat filter enabled by defining KEY_REPEAT_FILTER_EN.
module ir_key_fifo #(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 1000000
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [7:0]               Tecla,
    input  logic                     Ready,
    input  logic                     Clear,
    input  logic                     Key_Ack,
    output logic [7:0]               Key_Data,
    output logic                     Key_Valid,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1) begin : g_bad_cfg
        $error("ir_key_fifo: DEPTH must be a power of two >= 2 and HOLDOFF >= 1");
    end

    typedef enum logic {WAIT_PULSE, IN_PULSE} state_t;

    state_t          state_q, state_d;
    logic            arm_q, arm_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic            cap, drop, keep, full, pop, push;

`ifdef KEY_REPEAT_FILTER_EN
    logic [7:0]      last_key_q, last_key_d;
    logic [31:0]     hold_q, hold_d;

    always_comb begin
        drop       = (Tecla == last_key_q) && (hold_q != 32'd0);
        last_key_d = cap ? Tecla : last_key_q;
        hold_d     = cap ? 32'(HOLDOFF - 1) : ((hold_q != 32'd0) ? hold_q - 32'd1 : 32'd0);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            last_key_q <= 8'h00;
            hold_q     <= 32'd0;
        end else begin
            last_key_q <= last_key_d;
            hold_q     <= hold_d;
        end
    end
`else
    assign drop = 1'b0;
`endif

    // arm_q blocks a capture from the tail of a pulse that was in flight when reset hit
    always_comb begin
        cap     = (state_q == WAIT_PULSE) && Ready && arm_q;
        state_d = (state_q == WAIT_PULSE) ? (cap ? IN_PULSE : WAIT_PULSE)
                                          : (Ready ? IN_PULSE : WAIT_PULSE);
        arm_d   = arm_q | ~Ready;
        keep    = cap && !drop;
        full    = (count_q == CW'(DEPTH));
        pop     = (count_q != '0) && Key_Ack && !Clear;
        push    = keep && (!full || pop) && !Clear;
        ovf_d   = Clear ? 1'b0 : (ovf_q | (keep && full && !pop));
        wr_ptr_d = Clear ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d = Clear ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
        count_d  = Clear ? '0 : count_q + CW'(push) - CW'(pop);
        mem_d    = mem_q;
        if (push)
            mem_d[wr_ptr_q] = Tecla;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= WAIT_PULSE;
            arm_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign Key_Valid = (count_q != '0);
    assign Key_Data  = Key_Valid ? mem_q[rd_ptr_q] : 8'h00;
    assign Count     = count_q;
    assign Overflow  = ovf_q;
endmodule
